// File: rtl/posta_tile_writer_if.sv
// posta_tile_writer_if: tile capture side and pixel stream side of posta_tile_writer.
// master = surrounding environment (deconv core + feature-map writer), slave = tile writer.
interface posta_tile_writer_if #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = DATA_W + 8,
  parameter int SHIFT_W = 5
);
  logic                tile_valid;
  logic [ACC_W*16-1:0] tile_in_flat;
  logic [SHIFT_W-1:0]  shamt;
  logic                tile_ready;
  logic                pix_valid;
  logic                pix_ready;
  logic [DATA_W-1:0]   pix_data;
  logic [1:0]          pix_row;
  logic [1:0]          pix_col;
  logic                pix_last;
  logic                overflow;

  modport master (
    output tile_valid, tile_in_flat, shamt, pix_ready,
    input  tile_ready, pix_valid, pix_data, pix_row, pix_col, pix_last, overflow
  );

  modport slave (
    input  tile_valid, tile_in_flat, shamt, pix_ready,
    output tile_ready, pix_valid, pix_data, pix_row, pix_col, pix_last, overflow
  );
endinterface

// File: rtl/posta_tile_writer.sv
// posta_tile_writer: requantizes 4x4 accumulator tiles at capture, buffers up to two
// of them in a ping-pong store and streams them one pixel per cycle, row-major.
// Optional feature: define POSTA_SAT_EN to saturate on narrowing (default: wrap).
module posta_tile_writer #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = DATA_W + 8,
  parameter int SHIFT_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  posta_tile_writer_if.slave bus
);

  localparam int TILE_W = DATA_W * 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  // Round-half-up arithmetic right shift in ACC_W+1 bits, then narrow to DATA_W.
  function automatic logic [DATA_W-1:0] requant(input logic [ACC_W-1:0]   x,
                                                input logic [SHIFT_W-1:0] sh);
    int                      s_i;
    logic signed [ACC_W:0]   x_ext;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   y;
`ifdef POSTA_SAT_EN
    logic signed [ACC_W:0]   sat_max;
    logic signed [ACC_W:0]   sat_min;
`endif
    s_i = int'(sh);
    if (s_i > ACC_W - 1) begin
      s_i = ACC_W - 1;
    end
    x_ext = $signed({x[ACC_W-1], x});
    if (s_i > 0) begin
      rnd = {{ACC_W{1'b0}}, 1'b1} << (s_i - 1);
      y   = (x_ext + rnd) >>> s_i;
    end else begin
      y = x_ext;
    end
`ifdef POSTA_SAT_EN
    sat_max = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    sat_min = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    if (y > sat_max) begin
      requant = sat_max[DATA_W-1:0];
    end else if (y < sat_min) begin
      requant = sat_min[DATA_W-1:0];
    end else begin
      requant = y[DATA_W-1:0];
    end
`else
    requant = y[DATA_W-1:0];
`endif
  endfunction

  // Pixel idx (row-major) out of a stored tile word.
  function automatic logic [DATA_W-1:0] pick_pixel(input logic [TILE_W-1:0] word,
                                                   input logic [3:0]        idx);
    pick_pixel = word[idx*DATA_W +: DATA_W];
  endfunction

  logic [TILE_W-1:0] slot_r [2];
  logic [TILE_W-1:0] req_tile_s;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic [1:0]        count_nxt_s;
  rd_state_t         state_r;
  rd_state_t         state_nxt_s;
  logic              pix_valid_r;
  logic              pix_valid_nxt_s;
  logic [DATA_W-1:0] pix_data_r;
  logic [DATA_W-1:0] pix_data_nxt_s;
  logic [1:0]        pix_row_r;
  logic [1:0]        pix_col_r;
  logic              pix_last_r;
  logic [3:0]        idx_s;
  logic [3:0]        idx_nxt_s;
  logic              tile_ready_r;
  logic              overflow_r;
  logic              pop_s;
  logic              pop_last_s;
  logic              accept_s;
  logic              drop_s;
  logic              pending_s;

  assign idx_s = {pix_row_r, pix_col_r};

  // Requantize all 16 incoming elements with the shamt present at capture.
  always_comb begin
    req_tile_s = '0;
    for (int e = 0; e < 16; e++) begin
      req_tile_s[e*DATA_W +: DATA_W] = requant(bus.tile_in_flat[e*ACC_W +: ACC_W], bus.shamt);
    end
  end

  // Store bookkeeping: accept/drop decision and occupancy update.
  always_comb begin
    pop_s       = pix_valid_r && bus.pix_ready;
    pop_last_s  = pop_s && pix_last_r;
    accept_s    = bus.tile_valid && ((count_r != 2'd2) || pop_last_s);
    drop_s      = bus.tile_valid && !accept_s;
    pending_s   = (count_r == 2'd2) || accept_s;
    count_nxt_s = count_r;
    if (accept_s && !pop_last_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop_last_s && !accept_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Read FSM next state and next output pixel; a tile accepted in the same cycle
  // as the final pop is taken straight from the requant path to avoid a bubble.
  always_comb begin
    state_nxt_s     = state_r;
    pix_valid_nxt_s = pix_valid_r;
    pix_data_nxt_s  = pix_data_r;
    idx_nxt_s       = idx_s;
    case (state_r)
      ST_IDLE: begin
        if (count_r != 2'd0) begin
          state_nxt_s     = ST_STREAM;
          pix_valid_nxt_s = 1'b1;
          idx_nxt_s       = 4'd0;
          pix_data_nxt_s  = pick_pixel(slot_r[rd_ptr_r], 4'd0);
        end else begin
          state_nxt_s     = ST_IDLE;
          pix_valid_nxt_s = 1'b0;
          idx_nxt_s       = 4'd0;
        end
      end
      ST_STREAM: begin
        if (pop_last_s) begin
          idx_nxt_s = 4'd0;
          if (pending_s) begin
            state_nxt_s     = ST_STREAM;
            pix_valid_nxt_s = 1'b1;
            if (count_r == 2'd2) begin
              pix_data_nxt_s = pick_pixel(slot_r[~rd_ptr_r], 4'd0);
            end else begin
              pix_data_nxt_s = req_tile_s[DATA_W-1:0];
            end
          end else begin
            state_nxt_s     = ST_IDLE;
            pix_valid_nxt_s = 1'b0;
          end
        end else if (pop_s) begin
          idx_nxt_s      = idx_s + 4'd1;
          pix_data_nxt_s = pick_pixel(slot_r[rd_ptr_r], idx_s + 4'd1);
        end else begin
          idx_nxt_s = idx_s;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        pix_valid_nxt_s = 1'b0;
        idx_nxt_s       = 4'd0;
      end
    endcase
  end

  // State, output pixel register, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pix_valid_r  <= 1'b0;
      pix_data_r   <= '0;
      pix_row_r    <= 2'd0;
      pix_col_r    <= 2'd0;
      pix_last_r   <= 1'b0;
      count_r      <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      tile_ready_r <= 1'b1;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pix_valid_r  <= pix_valid_nxt_s;
      pix_data_r   <= pix_data_nxt_s;
      pix_row_r    <= idx_nxt_s[3:2];
      pix_col_r    <= idx_nxt_s[1:0];
      pix_last_r   <= (idx_nxt_s == 4'd15);
      count_r      <= count_nxt_s;
      tile_ready_r <= (count_nxt_s != 2'd2);
      if (accept_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_last_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Slot storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      slot_r[wr_ptr_r] <= req_tile_s;
    end
  end

  assign bus.tile_ready = tile_ready_r;
  assign bus.pix_valid  = pix_valid_r;
  assign bus.pix_data   = pix_data_r;
  assign bus.pix_row    = pix_row_r;
  assign bus.pix_col    = pix_col_r;
  assign bus.pix_last   = pix_last_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_posta_tile_writer.sv
// tb_posta_tile_writer: randomized and directed stimulus against a queue-based
// reference model of the tile writer (requant arithmetic, 2-tile store, stream order).
module tb_posta_tile_writer;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 24;
  localparam int SHIFT_W = 5;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                row;
    int                col;
    bit                last;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  posta_tile_writer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) bus ();

  posta_tile_writer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pix_t exp_q[$];
  bit   exp_valid;
  bit   exp_ovf;
  bit   exp_tr;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_total = 0;

  function automatic logic [DATA_W-1:0] ref_requant(input longint x, input int sh);
    int     s;
    longint y;
    longint hi;
    longint lo;
    s = (sh > ACC_W - 1) ? ACC_W - 1 : sh;
    if (s > 0) y = (x + (longint'(1) << (s - 1))) >>> s;
    else       y = x;
    hi = (longint'(1) << (DATA_W - 1)) - 1;
    lo = -(longint'(1) << (DATA_W - 1));
`ifdef POSTA_SAT_EN
    if (y > hi) y = hi;
    else if (y < lo) y = lo;
`endif
    return DATA_W'(y);
  endfunction

  task automatic push_tile(input logic [ACC_W*16-1:0] t, input int sh);
    for (int i = 0; i < 16; i++) begin
      logic signed [ACC_W-1:0] e;
      pix_t p;
      e      = t[i*ACC_W +: ACC_W];
      p.data = ref_requant(longint'(e), sh);
      p.row  = i / 4;
      p.col  = i % 4;
      p.last = (i == 15);
      exp_q.push_back(p);
    end
  endtask

  task automatic gen_tile(output logic [ACC_W*16-1:0] t);
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) t[i*ACC_W +: ACC_W] = ACC_W'($urandom_range(0, 511) - 256);
      else                           t[i*ACC_W +: ACC_W] = ACC_W'($urandom);
    end
  endtask

  // Compare current outputs with the model, advance the model over the coming edge, clock.
  task automatic step();
    int cnt;
    int pre_push;
    bit pl;
    n_checks++;
    if (bus.pix_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL pix_valid: got %0b want %0b at %0t", bus.pix_valid, exp_valid, $time);
    end
    n_checks++;
    if (bus.tile_ready !== exp_tr) begin
      n_fail++;
      $display("FAIL tile_ready: got %0b want %0b at %0t", bus.tile_ready, exp_tr, $time);
    end
    n_checks++;
    if (bus.overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %0b want %0b at %0t", bus.overflow, exp_ovf, $time);
    end
    if (exp_valid && exp_q.size() > 0) begin
      n_checks++;
      if (bus.pix_data !== exp_q[0].data || bus.pix_row !== 2'(exp_q[0].row) ||
          bus.pix_col !== 2'(exp_q[0].col) || bus.pix_last !== exp_q[0].last) begin
        n_fail++;
        $display("FAIL pixel: got d=%0d r=%0d c=%0d l=%0b want d=%0d r=%0d c=%0d l=%0b at %0t",
                 $signed(bus.pix_data), bus.pix_row, bus.pix_col, bus.pix_last,
                 $signed(exp_q[0].data), exp_q[0].row, exp_q[0].col, exp_q[0].last, $time);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_tr    = 1'b1;
    end else begin
      cnt = (exp_q.size() + 15) / 16;
      pl  = 1'b0;
      if (exp_valid && bus.pix_ready) begin
        pl = exp_q[0].last;
        void'(exp_q.pop_front());
        hs_total++;
      end
      pre_push = exp_q.size();
      if (bus.tile_valid) begin
        if (cnt < 2 || pl) push_tile(bus.tile_in_flat, int'(bus.shamt));
        else exp_ovf = 1'b1;
      end
      exp_valid = exp_valid ? (exp_q.size() > 0) : (pre_push > 0);
      exp_tr    = ((exp_q.size() + 15) / 16) < 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int guard = 0;
    bus.tile_valid = 1'b0;
    bus.pix_ready  = 1'b1;
    while ((exp_q.size() != 0 || exp_valid) && guard < budget) begin
      step();
      guard++;
    end
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d pixels pending after %0d cycles", exp_q.size(), guard);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tile_valid = 1'b0; bus.tile_in_flat = '0; bus.shamt = '0; bus.pix_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    exp_q.delete(); exp_valid = 1'b0; exp_ovf = 1'b0; exp_tr = 1'b1;
    n_checks++;
    if ({bus.pix_valid, bus.pix_data, bus.pix_row, bus.pix_col, bus.pix_last, bus.tile_ready, bus.overflow}
        !== {1'b0, 16'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got v=%0b d=%0d r=%0d c=%0d l=%0b tr=%0b ov=%0b want 0 0 0 0 0 1 0",
               bus.pix_valid, bus.pix_data, bus.pix_row, bus.pix_col, bus.pix_last, bus.tile_ready, bus.overflow);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rounding();
    logic [ACC_W*16-1:0] t;
    for (int i = 0; i < 16; i++) t[i*ACC_W +: ACC_W] = ACC_W'(16 * i + 8);
    bus.tile_in_flat = t; bus.shamt = 5'd4; bus.pix_ready = 1'b1; bus.tile_valid = 1'b1;
    step();
    bus.tile_valid = 1'b0;
    n_checks++;
    if (bus.pix_valid !== 1'b0) begin
      n_fail++; $display("FAIL round_latency_early: got pix_valid=%0b want 0", bus.pix_valid);
    end
    step();
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== 16'(k + 1) || bus.pix_last !== (k == 15)) begin
        n_fail++;
        $display("FAIL round_pixel%0d: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                 k, bus.pix_valid, bus.pix_data, bus.pix_last, k + 1, (k == 15));
      end
      step();
    end
    drain(8);
  endtask

  task automatic test_saturation();
    logic [ACC_W*16-1:0] t;
    logic [DATA_W-1:0]   want;
    for (int i = 0; i < 16; i++) t[i*ACC_W +: ACC_W] = (i % 2 == 0) ? 24'h100000 : 24'hF00000;
    bus.tile_in_flat = t; bus.shamt = 5'd0; bus.pix_ready = 1'b1; bus.tile_valid = 1'b1;
    step();
    bus.tile_valid = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
`ifdef POSTA_SAT_EN
      want = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
`else
      want = 16'h0000;
`endif
      n_checks++;
      if (bus.pix_valid !== 1'b1 || bus.pix_data !== want) begin
        n_fail++;
        $display("FAIL sat_pixel%0d: got v=%0b d=%0h want v=1 d=%0h", k, bus.pix_valid, bus.pix_data, want);
      end
      step();
    end
    drain(8);
  endtask

  task automatic test_backpressure();
    logic [ACC_W*16-1:0] t;
    int hs0;
    int guard = 0;
    gen_tile(t);
    bus.tile_in_flat = t; bus.shamt = 5'($urandom_range(0, 31)); bus.tile_valid = 1'b1;
    bus.pix_ready = 1'b1;
    hs0 = hs_total;
    step();
    bus.tile_valid = 1'b0;
    while ((exp_q.size() != 0 || exp_valid) && guard < 100) begin
      bus.pix_ready = (guard % 4 == 0 || guard % 4 == 3);
      step();
      guard++;
    end
    n_checks++;
    if (hs_total - hs0 != 16 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_handshakes: got %0d handshakes (%0d left) want 16", hs_total - hs0, exp_q.size());
    end
    drain(8);
  endtask

  task automatic test_overflow();
    logic [ACC_W*16-1:0] t;
    int hs0;
    bus.pix_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      gen_tile(t);
      bus.tile_in_flat = t; bus.shamt = 5'($urandom_range(0, 31)); bus.tile_valid = 1'b1;
      step();
      if (n == 1) begin
        n_checks++;
        if (bus.tile_ready !== 1'b0) begin
          n_fail++; $display("FAIL ovf_tile_ready: got %0b want 0", bus.tile_ready);
        end
      end
    end
    bus.tile_valid = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %0b want 1", bus.overflow);
    end
    hs0 = hs_total;
    drain(80);
    n_checks++;
    if (hs_total - hs0 != 32) begin
      n_fail++; $display("FAIL ovf_pixels: got %0d handshakes want 32", hs_total - hs0);
    end
  endtask

  task automatic test_reset_mid();
    logic [ACC_W*16-1:0] t;
    int guard = 0;
    gen_tile(t);
    bus.tile_in_flat = t; bus.shamt = 5'd3; bus.pix_ready = 1'b1; bus.tile_valid = 1'b1;
    step();
    bus.tile_valid = 1'b0;
    while (!(exp_valid && exp_q.size() == 9) && guard < 40) begin step(); guard++; end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({bus.pix_valid, bus.pix_data, bus.pix_row, bus.pix_col, bus.pix_last, bus.tile_ready, bus.overflow}
        !== {1'b0, 16'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_values: got v=%0b d=%0d r=%0d c=%0d l=%0b tr=%0b ov=%0b want 0 0 0 0 0 1 0",
               bus.pix_valid, bus.pix_data, bus.pix_row, bus.pix_col, bus.pix_last, bus.tile_ready, bus.overflow);
    end
    gen_tile(t);
    bus.tile_in_flat = t; bus.tile_valid = 1'b1;
    step();
    bus.tile_valid = 1'b0;
    step();
    n_checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_row !== 2'd0 || bus.pix_col !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_restart: got v=%0b r=%0d c=%0d want v=1 r=0 c=0", bus.pix_valid, bus.pix_row, bus.pix_col);
    end
    drain(40);
  endtask

  task automatic test_simultaneous();
    logic [ACC_W*16-1:0] t;
    int hs0;
    int guard = 0;
    bit fired = 1'b0;
    bus.pix_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      gen_tile(t);
      bus.tile_in_flat = t; bus.shamt = 5'($urandom_range(0, 31)); bus.tile_valid = 1'b1;
      step();
    end
    bus.tile_valid = 1'b0;
    hs0 = hs_total;
    bus.pix_ready = 1'b1;
    while (!fired && guard < 64) begin
      if (exp_valid && exp_q.size() == 17) begin
        gen_tile(t);
        bus.tile_in_flat = t; bus.shamt = 5'($urandom_range(0, 31)); bus.tile_valid = 1'b1;
        step();
        bus.tile_valid = 1'b0;
        fired = 1'b1;
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.tile_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL simul_accept: got ov=%0b tr=%0b want ov=0 tr=0", bus.overflow, bus.tile_ready);
        end
      end else begin
        step();
      end
      guard++;
    end
    n_checks++;
    if (!fired) begin
      n_fail++; $display("FAIL simul_timeout: got no last-pixel window want one within 64 cycles");
    end
    drain(80);
    n_checks++;
    if (hs_total - hs0 != 48) begin
      n_fail++; $display("FAIL simul_pixels: got %0d handshakes want 48", hs_total - hs0);
    end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W*16-1:0] t;
    int hs0;
    hs0 = hs_total;
    bus.pix_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c % 16 == 0 && c < 48) begin
        gen_tile(t);
        bus.tile_in_flat = t; bus.shamt = 5'($urandom_range(0, 31)); bus.tile_valid = 1'b1;
      end else begin
        bus.tile_valid = 1'b0;
      end
      step();
    end
    n_checks++;
    if (hs_total - hs0 != 48) begin
      n_fail++; $display("FAIL b2b_pixels: got %0d handshakes in 60 cycles want 48", hs_total - hs0);
    end
    drain(40);
  endtask

  task automatic test_random();
    logic [ACC_W*16-1:0] t;
    for (int c = 0; c < 600; c++) begin
      bus.pix_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        gen_tile(t);
        bus.tile_in_flat = t; bus.shamt = 5'($urandom_range(0, 31)); bus.tile_valid = 1'b1;
      end else begin
        bus.tile_valid = 1'b0;
      end
      step();
    end
    drain(80);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/posta_tile_writer.md
# posta_tile_writer

Downstream stage of the POSTA deconvolution core. It captures each flattened 4x4 output tile (ACC_W per element) in the cycle it is produced and requantizes it to DATA_W with a runtime right-shift, round-half-up and optional saturation. It buffers up to two tiles in a ping-pong store and serializes them one pixel per cycle, row-major, on a valid/ready stream toward the feature-map writer. The deconv core has no backpressure, so tiles that arrive while both slots are full are dropped and flagged.

## Interface

- DATA_W, 16, output pixel width (signed)
- ACC_W, DATA_W+8, input tile element width (signed)
- SHIFT_W, 5, width of shamt

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk edge
- tile_valid  in  1  tile_in_flat holds a new tile this cycle; single-cycle pulse per tile
- tile_in_flat  in  ACC_W*16  element (r,c) at bits [(r*4+c)*ACC_W +: ACC_W]
- shamt  in  SHIFT_W  requant right-shift, sampled on tile capture
- tile_ready  out  1  at least one slot free (advisory; upstream does not stall)
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  DATA_W  requantized pixel
- pix_row  out  2  row index within tile
- pix_col  out  2  column index within tile
- pix_last  out  1  high with pixel (3,3)
- overflow  out  1  sticky: a tile was dropped

## Operation

- Requant per element x: s = min(shamt, ACC_W-1). If s>0, y = (x + 2^(s-1)) >>> s, else y = x. Compute the add in ACC_W+1 bits, so no intermediate wrap. Then narrow to DATA_W (see Configuration).
- Requant happens at capture. Slots store DATA_W*16 bits. Later shamt changes do not affect stored tiles.
- Store: 2 slots with write pointer, read pointer and count (0..2).
- Accept condition: tile_valid && (count<2 || pop_last). pop_last = pix_valid && pix_ready && pix_last. An accepted tile goes to the write slot and the write pointer toggles.
- Drop: tile_valid && count==2 && !pop_last. The tile is discarded, overflow is set to 1, and count and pointers are unchanged.
- Count update: +1 on accept without pop_last, -1 on pop_last without accept, unchanged when both or neither occur.
- Read FSM:
  - IDLE: when count>0, load pixel (0,0) of the read slot into the output register and go to STREAM.
  - STREAM: on each pix_valid&&pix_ready, advance the index in row-major order.
  - On the pop of index 15: release the slot and toggle the read pointer. If another tile is pending (including one accepted this cycle), present its (0,0) next cycle without a bubble; otherwise go to IDLE.
- While pix_valid && !pix_ready, pix_data, pix_row, pix_col and pix_last hold stable.
- tile_ready = (count<2), driven from registered state.
- overflow clears only on reset.

## Timing

- Reset values: pix_valid=0, pix_data=0, pix_row=0, pix_col=0, pix_last=0, tile_ready=1, overflow=0. Count=0, pointers=0, FSM=IDLE. Slot contents are don't-care.
- Reset mid-stream aborts the current tile and discards buffered tiles. pix_valid is 0 in the cycle after reset is sampled.
- Latency: a tile captured at edge N into an empty block gives pix_valid=1 with pixel (0,0) after edge N+1.
- Throughput: with pix_ready held high, 16 consecutive pixel cycles per tile and back-to-back tiles with no gap. This sustains one tile per 16 cycles.
- Simultaneous accept and pop_last with count==2: the tile is accepted, no drop occurs, and overflow is unchanged.

## Configuration

- POSTA_SAT_EN defined: narrowing saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- POSTA_SAT_EN undefined: narrowing keeps the low DATA_W bits (two's-complement wrap), which saves the comparators.

## Test plan

- Rounding, with shamt=4, DATA_W=16, ACC_W=24 and pix_ready=1: element i = 16*i+8 gives pixels 1..16 in row-major order. pix_last is high only on the 16th pixel. Pixel (0,0) appears one cycle after capture.
- Saturation, shamt=0, elements alternating +2^20 and -2^20: with POSTA_SAT_EN the outputs are 32767 and -32768; without it both are 0.
- Backpressure: capture one tile, then toggle pix_ready 1,0,0,1,... Data is held stable while stalled, the sequence shows no loss or duplication, and exactly 16 handshakes occur.
- Overflow: with pix_ready=0, send 3 tiles at 1-cycle spacing. Tiles 1 and 2 are buffered and tile_ready drops to 0 after tile 2. Tile 3 is dropped and overflow=1. Releasing pix_ready yields 32 pixels from tiles 1 and 2.
- Simultaneous event: with count==2, drive tile_valid in the same cycle as the pop of pixel 15. Expect no overflow, and the new tile appears after the remaining buffered tile.
- Reset mid-stream: assert rst_n=0 for one cycle at pixel 7. The next cycle shows all outputs at reset values and overflow=0. A new tile afterwards streams from (0,0).
